// File: rtl/icache_pkg.sv
// icache_pkg: shared geometry, FSM state encoding and tree-PLRU helpers for
// the 4-way, 32-set, 256-bit-line instruction cache controller.
//   plru_victim(valid, lru) -> way to replace (lowest invalid first, else PLRU)
//   plru_update(way, lru)   -> PLRU bits pointing away from the accessed way
package icache_pkg;

  localparam int TAG_W  = 22;
  localparam int IDX_W  = 5;
  localparam int OFF_W  = 5;
  localparam int LINE_W = 256;
  localparam int WAYS   = 4;
  localparam int BEATS  = 8;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEM_REQ = 2'd1,
    ST_REFILL  = 2'd2,
    ST_WRITE   = 2'd3
  } state_t;

  // lru[0]=1 sends the victim to the {2,3} half; lru[1] picks within {0,1}
  // (1 -> way 1), lru[2] picks within {2,3} (1 -> way 3).
  function automatic logic [1:0] plru_victim(input logic [3:0] valid,
                                             input logic [2:0] lru);
    logic [1:0] v;
    if (!valid[0])      v = 2'd0;
    else if (!valid[1]) v = 2'd1;
    else if (!valid[2]) v = 2'd2;
    else if (!valid[3]) v = 2'd3;
    else if (lru[0])    v = lru[2] ? 2'd3 : 2'd2;
    else                v = lru[1] ? 2'd1 : 2'd0;
    return v;
  endfunction

  // The bit not on the accessed way's path is left untouched.
  function automatic logic [2:0] plru_update(input logic [1:0] way,
                                             input logic [2:0] lru);
    logic [2:0] n;
    n = lru;
    case (way)
      2'd0:    begin n[0] = 1'b1; n[1] = 1'b1; end
      2'd1:    begin n[0] = 1'b1; n[1] = 1'b0; end
      2'd2:    begin n[0] = 1'b0; n[2] = 1'b1; end
      default: begin n[0] = 1'b0; n[2] = 1'b0; end
    endcase
    return n;
  endfunction

endpackage

// File: rtl/icache_plru.sv
// icache_plru: combinational replacement logic for one cache set.
//   valid_rd  in  4  valid bits of the indexed set
//   lru_rd    in  3  current PLRU bits of the indexed set
//   acc_way   in  2  way being accessed (hit way or refill victim)
//   victim    out 2  way to replace on refill
//   lru_wdata out 3  PLRU bits after accessing acc_way
module icache_plru
  import icache_pkg::*;
(
  input  logic [3:0] valid_rd,
  input  logic [2:0] lru_rd,
  input  logic [1:0] acc_way,
  output logic [1:0] victim,
  output logic [2:0] lru_wdata
);

  assign victim    = plru_victim(valid_rd, lru_rd);
  assign lru_wdata = plru_update(acc_way, lru_rd);

endmodule

// File: rtl/icache_ctrl.sv
// icache_ctrl: instruction cache controller. Single-cycle hit lookup against
// asynchronously read tag/valid/LRU/data arrays; on a miss it stalls fetch,
// requests the line, gathers 8 beats, then writes the victim way in one cycle.
//   clk, rst_n                 clock, asynchronous active-low reset
//   cpu_req_valid/cpu_addr     fetch request and byte address
//   cpu_rdata/cpu_hit/cpu_stall fetch response and PC freeze
//   mem_req_valid/addr/ready   line read request handshake
//   mem_rvalid/mem_rdata       refill beats
//   arr_*                      array index and write controls/data
//   tag_rd/valid_rd/lru_rd/data_rd  array read data for arr_idx
module icache_ctrl
  import icache_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req_valid,
  input  logic [31:0]   cpu_addr,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_hit,
  output logic          cpu_stall,
  output logic          mem_req_valid,
  output logic [31:0]   mem_req_addr,
  input  logic          mem_req_ready,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata,
  output logic [4:0]    arr_idx,
  output logic [21:0]   arr_tag_wdata,
  output logic [3:0]    arr_way_we,
  output logic [255:0]  arr_data_wdata,
  output logic          arr_lru_we,
  output logic [2:0]    arr_lru_wdata,
  input  logic [87:0]   tag_rd,
  input  logic [3:0]    valid_rd,
  input  logic [2:0]    lru_rd,
  input  logic [1023:0] data_rd
);

  localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);

  state_t              state_reg, state_next;
  logic [TAG_W-1:0]    miss_tag_reg;
  logic [IDX_W-1:0]    miss_idx_reg;
  logic [2:0]          beat_cnt_reg;
  logic [LINE_W-1:0]   line_reg;

  logic [WAYS-1:0]     hit_vec;
  logic [LINE_W-1:0]   way_line [WAYS];
  logic [1:0]          hit_way;
  logic [LINE_W-1:0]   hit_line;
  logic                lookup_hit;
  logic                is_idle;
  logic                miss;
  logic [1:0]          victim;
  logic [1:0]          acc_way;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr[1:0];

  // Per-way tag compare and line extraction.
  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      assign hit_vec[gi]  = valid_rd[gi] &&
                            (tag_rd[gi*TAG_W +: TAG_W] == cpu_addr[31:10]);
      assign way_line[gi] = data_rd[gi*LINE_W +: LINE_W];
    end
  endgenerate

  // At most one way can hit, so a priority encode is a plain encoder.
  always_comb begin
    hit_way = 2'd0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit_vec[w]) hit_way = 2'(w);
    end
  end

  assign hit_line   = way_line[hit_way];
  assign cpu_rdata  = hit_line[{cpu_addr[4:2], 5'b0} +: WORD_W];

  assign is_idle    = (state_reg == ST_IDLE);
  assign lookup_hit = is_idle && (|hit_vec);
  assign cpu_hit    = cpu_req_valid && lookup_hit;
  assign miss       = is_idle && cpu_req_valid && !(|hit_vec);
  assign cpu_stall  = miss || !is_idle;

  // Arrays are indexed by the live fetch address only while looking up;
  // afterwards the latched miss set must stay put even if fetch redirects.
  assign arr_idx        = is_idle ? cpu_addr[9:5] : miss_idx_reg;
  assign mem_req_addr   = {miss_tag_reg, miss_idx_reg, 5'b0};
  assign arr_tag_wdata  = miss_tag_reg;
  assign arr_data_wdata = line_reg;

  icache_plru u_plru (
    .valid_rd  (valid_rd),
    .lru_rd    (lru_rd),
    .acc_way   (acc_way),
    .victim    (victim),
    .lru_wdata (arr_lru_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      miss_tag_reg <= '0;
      miss_idx_reg <= '0;
      beat_cnt_reg <= '0;
      line_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (miss) begin
        miss_tag_reg <= cpu_addr[31:10];
        miss_idx_reg <= cpu_addr[9:5];
      end
      if (state_reg == ST_MEM_REQ && mem_req_ready) begin
        beat_cnt_reg <= '0;
      end
      if (state_reg == ST_REFILL && mem_rvalid) begin
        line_reg[{beat_cnt_reg, 5'b0} +: WORD_W] <= mem_rdata;
        beat_cnt_reg <= beat_cnt_reg + 3'd1;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    mem_req_valid = 1'b0;
    arr_way_we    = '0;
    arr_lru_we    = 1'b0;
    acc_way       = hit_way;
    case (state_reg)
      ST_IDLE: begin
        arr_lru_we = cpu_hit;
        if (miss) state_next = ST_MEM_REQ;
      end
      ST_MEM_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_next = ST_REFILL;
      end
      ST_REFILL: begin
        if (mem_rvalid && beat_cnt_reg == LAST_BEAT) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        acc_way             = victim;
        arr_way_we[victim]  = 1'b1;
        arr_lru_we          = 1'b1;
        state_next          = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule
